// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the 4-stage 8-bit pipeline.
// Holds the opcode encoding, instruction field positions and the
// default datapath/register-address widths used by every stage.
package pipe_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int AW_DEFAULT = 3;
    localparam int IW         = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MOV = 2'b10,
        OP_JMP = 2'b11
    } opcode_t;

    // Instruction layout: [7:6] opcode, [5:3] rd, [2:0] rs, [5:0] jump target
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 3;
    localparam int RS_HI  = 2;
    localparam int RS_LO  = 0;
    localparam int TGT_HI = 5;
    localparam int TGT_LO = 0;
    localparam int TGT_W  = TGT_HI - TGT_LO + 1;

    function automatic opcode_t get_opcode(input logic [IW-1:0] instr);
        return opcode_t'(instr[OP_HI:OP_LO]);
    endfunction

endpackage

// File: rtl/exwb_stage_if.sv
// exwb_stage_if: bundle between decode/register file and the EX/WB stage.
// The master side presents the instruction and operands; the slave side
// (the stage itself) returns the write-back triple, redirect and flags.
interface exwb_stage_if
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
);

    logic              id_valid;
    logic [IW-1:0]     id_instr;
    logic [DW-1:0]     rd_data1;
    logic [DW-1:0]     rd_data2;

    logic              wb_reg_write;
    logic [AW-1:0]     wb_reg;
    logic [DW-1:0]     wb_data;
    logic              br_taken;
    logic [TGT_W-1:0]  br_target;
    logic              flag_z;
    logic              flag_c;

    modport master (
        output id_valid, id_instr, rd_data1, rd_data2,
        input  wb_reg_write, wb_reg, wb_data, br_taken, br_target, flag_z, flag_c
    );

    modport slave (
        input  id_valid, id_instr, rd_data1, rd_data2,
        output wb_reg_write, wb_reg, wb_data, br_taken, br_target, flag_z, flag_c
    );

endinterface

// File: rtl/alu8.sv
// alu8: combinational ADD/SUB/MOV unit for the EX/WB stage.
// SUB reports a borrow in the carry output (set when a < b unsigned).
// JMP is not an ALU operation and returns zeros.
module alu8
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  opcode_t       op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);

    logic [DW:0] ext;

    // Compute a DW+1 bit result so the top bit is the carry/borrow
    always_comb begin
        ext = '0;
        case (op)
            OP_ADD:  ext = {1'b0, a} + {1'b0, b};
            OP_SUB:  ext = {1'b0, a} - {1'b0, b};
            OP_MOV:  ext = {1'b0, b};
            default: ext = '0;
        endcase
        result = ext[DW-1:0];
        carry  = ext[DW];
        zero   = (ext[DW-1:0] == '0);
    end

endmodule

// File: rtl/exwb_stage.sv
// exwb_stage: execute/write-back stage of the 4-stage 8-bit pipeline.
// Runs one instruction per cycle through alu8 and registers the
// register-file write port, the jump redirect pulse and the Z/C flags.
// A taken jump squashes the single instruction presented behind it.
// Optional feature macro: EXWB_FWD_EN enables one-deep result forwarding
// from the registered write-back into the A/B operands.
module exwb_stage
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input logic         clk,
    input logic         rst,
    exwb_stage_if.slave bus
);

    opcode_t          op;
    logic [AW-1:0]    rd;
    logic [DW-1:0]    op_a;
    logic [DW-1:0]    op_b;
    logic [DW-1:0]    alu_result;
    logic             alu_carry;
    logic             alu_zero;
    logic             accept;

    logic             wb_reg_write_q;
    logic [AW-1:0]    wb_reg_q;
    logic [DW-1:0]    wb_data_q;
    logic             br_taken_q;
    logic [TGT_W-1:0] br_target_q;
    logic             flag_z_q;
    logic             flag_c_q;

    assign op = get_opcode(bus.id_instr);
    assign rd = bus.id_instr[RD_HI:RD_LO];

    // The slot right after a taken jump holds the wrong-path instruction
    assign accept = bus.id_valid && !br_taken_q;

`ifdef EXWB_FWD_EN
    logic [AW-1:0] rs;
    assign rs = bus.id_instr[RS_HI:RS_LO];

    // The register file has not yet committed last cycle's result, so take it from wb
    always_comb begin
        op_a = bus.rd_data1;
        op_b = bus.rd_data2;
        if (wb_reg_write_q && (wb_reg_q == rd)) begin
            op_a = wb_data_q;
        end
        if (wb_reg_write_q && (wb_reg_q == rs)) begin
            op_b = wb_data_q;
        end
    end
`else
    assign op_a = bus.rd_data1;
    assign op_b = bus.rd_data2;
`endif

    alu8 #(.DW(DW)) u_alu (
        .op     (op),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Pipeline register: write-back triple, redirect pulse and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_reg_write_q <= 1'b0;
            wb_reg_q       <= '0;
            wb_data_q      <= '0;
            br_taken_q     <= 1'b0;
            br_target_q    <= '0;
            flag_z_q       <= 1'b0;
            flag_c_q       <= 1'b0;
        end else begin
            wb_reg_write_q <= 1'b0;
            br_taken_q     <= 1'b0;
            if (accept) begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        wb_reg_write_q <= 1'b1;
                        wb_reg_q       <= rd;
                        wb_data_q      <= alu_result;
                        flag_z_q       <= alu_zero;
                        flag_c_q       <= alu_carry;
                    end
                    OP_MOV: begin
                        wb_reg_write_q <= 1'b1;
                        wb_reg_q       <= rd;
                        wb_data_q      <= alu_result;
                    end
                    default: begin
                        br_taken_q  <= 1'b1;
                        br_target_q <= bus.id_instr[TGT_HI:TGT_LO];
                    end
                endcase
            end
        end
    end

    assign bus.wb_reg_write = wb_reg_write_q;
    assign bus.wb_reg       = wb_reg_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.br_taken     = br_taken_q;
    assign bus.br_target    = br_target_q;
    assign bus.flag_z       = flag_z_q;
    assign bus.flag_c       = flag_c_q;

endmodule

// File: tb/tb_exwb_stage.sv
// tb_exwb_stage: self-checking bench for exwb_stage.
// Each scenario task pushes the expected post-edge output state into a
// scoreboard as it drives an instruction and compares it one edge later.
// Build with or without EXWB_FWD_EN; forwarding-dependent values adapt.
module tb_exwb_stage;
    import pipe_pkg::*;

    typedef struct packed {
        logic       we;
        logic [2:0] rg;
        logic [7:0] data;
        logic       z;
        logic       c;
        logic       br;
    } obs_t;

    typedef struct packed {
        logic       v;
        logic [7:0] instr;
        logic [7:0] d1;
        logic [7:0] d2;
        obs_t       exp;
    } step_t;

`ifdef EXWB_FWD_EN
    localparam logic [7:0] FWD_R2   = 8'd5;
    localparam logic [7:0] FWD_R3   = 8'd7;
    localparam logic [7:0] FWD_R4   = 8'd14;
    localparam logic [7:0] B2B_LAST = 8'd16;
    localparam bit         FWD_ON   = 1'b1;
`else
    localparam logic [7:0] FWD_R2   = 8'd3;
    localparam logic [7:0] FWD_R3   = 8'd5;
    localparam logic [7:0] FWD_R4   = 8'd4;
    localparam logic [7:0] B2B_LAST = 8'd2;
    localparam bit         FWD_ON   = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    exwb_stage_if #(.DW(8), .AW(3)) bus ();

    exwb_stage #(.DW(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic obs_t mk(input logic we, input logic [2:0] rg, input logic [7:0] data,
                                input logic z, input logic c, input logic br);
        obs_t o;
        o.we = we; o.rg = rg; o.data = data; o.z = z; o.c = c; o.br = br;
        return o;
    endfunction

    function automatic step_t mks(input logic v, input logic [7:0] instr, input logic [7:0] d1,
                                  input logic [7:0] d2, input obs_t exp);
        step_t s;
        s.v = v; s.instr = instr; s.d1 = d1; s.d2 = d2; s.exp = exp;
        return s;
    endfunction

    function automatic obs_t sample();
        return mk(bus.wb_reg_write, bus.wb_reg, bus.wb_data, bus.flag_z, bus.flag_c, bus.br_taken);
    endfunction

    function automatic string show(input obs_t o);
        return $sformatf("we=%0b reg=%0d data=%0d z=%0b c=%0b br=%0b", o.we, o.rg, o.data, o.z, o.c, o.br);
    endfunction

    task automatic drive(input step_t s);
        @(negedge clk);
        bus.id_valid = s.v;
        bus.id_instr = s.instr;
        bus.rd_data1 = s.d1;
        bus.rd_data2 = s.d2;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        step_t s;
        bus.id_valid = 1'b0;
        bus.id_instr = 8'h00;
        bus.rd_data1 = 8'h00;
        bus.rd_data2 = 8'h00;
        #1 rst = 1'b1;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        got = sample(); exp = sb.pop_front(); n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_initial: got %s, expected %s", show(got), show(exp));
        end
        @(negedge clk);
        #1 rst = 1'b0;

        s = mks(1, 8'b00_100_000, 8'd200, 8'd100, mk(1, 4, 8'd44, 0, 1, 0));
        sb.push_back(s.exp);
        drive(s);
        @(posedge clk); #1;
        got = sample(); exp = sb.pop_front(); n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_pre_add: got %s, expected %s", show(got), show(exp));
        end

        s = mks(1, 8'b00_101_000, 8'd1, 8'd1, mk(0, 0, 0, 0, 0, 0));
        drive(s);
        #2 rst = 1'b1;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        got = sample(); exp = sb.pop_front(); n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_async: got %s, expected %s", show(got), show(exp));
        end
        @(posedge clk); #1;
        sb.push_back(s.exp);
        got = sample(); exp = sb.pop_front(); n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_inflight: got %s, expected %s", show(got), show(exp));
        end
        bus.id_valid = 1'b0;
        #1 rst = 1'b0;
    endtask

    task automatic test_add_carry();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mks(0, 8'h00,        8'd0,   8'd0,   mk(0, 0, 8'd0,  0, 0, 0)));
        s.push_back(mks(1, 8'b00_001_010, 8'd200, 8'd100, mk(1, 1, 8'd44, 0, 1, 0)));
        s.push_back(mks(1, 8'b00_010_011, 8'd128, 8'd128, mk(1, 2, 8'd0,  1, 1, 0)));
        s.push_back(mks(1, 8'b00_011_100, 8'd15,  8'd16,  mk(1, 3, 8'd31, 0, 0, 0)));
        foreach (s[i]) begin
            sb.push_back(s[i].exp);
            drive(s[i]);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("[TB] FAIL add_carry[%0d]: got %s, expected %s", i, show(got), show(exp));
            end
        end
    endtask

    task automatic test_sub();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mks(0, 8'h00,        8'd0,   8'd0,   mk(0, 3, 8'd31,  0, 0, 0)));
        s.push_back(mks(1, 8'b01_011_101, 8'd5,   8'd5,   mk(1, 3, 8'd0,   1, 0, 0)));
        s.push_back(mks(0, 8'h00,        8'd0,   8'd0,   mk(0, 3, 8'd0,   1, 0, 0)));
        s.push_back(mks(1, 8'b01_011_101, 8'd3,   8'd4,   mk(1, 3, 8'd255, 0, 1, 0)));
        s.push_back(mks(1, 8'b01_100_000, 8'h80,  8'h7F,  mk(1, 4, 8'd1,   0, 0, 0)));
        foreach (s[i]) begin
            sb.push_back(s[i].exp);
            drive(s[i]);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("[TB] FAIL sub[%0d]: got %s, expected %s", i, show(got), show(exp));
            end
        end
    endtask

    task automatic test_forwarding();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mks(0, 8'h00,        8'd0, 8'd0, mk(0, 4, 8'd1,   0, 0, 0)));
        s.push_back(mks(1, 8'b00_001_010, 8'd1, 8'd2, mk(1, 1, 8'd3,   0, 0, 0)));
        s.push_back(mks(1, 8'b00_001_010, 8'd1, 8'd2, mk(1, 1, FWD_R2, 0, 0, 0)));
        s.push_back(mks(1, 8'b00_010_001, 8'd2, 8'd3, mk(1, 2, FWD_R3, 0, 0, 0)));
        s.push_back(mks(1, 8'b00_010_010, 8'd2, 8'd2, mk(1, 2, FWD_R4, 0, 0, 0)));
        foreach (s[i]) begin
            sb.push_back(s[i].exp);
            drive(s[i]);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("[TB] FAIL forwarding[%0d]: got %s, expected %s", i, show(got), show(exp));
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t      s[$];
        obs_t       got, exp;
        logic [7:0] acc;
        s.push_back(mks(0, 8'h00, 8'd0, 8'd0, mk(0, 2, FWD_R4, 0, 0, 0)));
        acc = 8'd2;
        for (int k = 0; k < 4; k++) begin
            s.push_back(mks(1, 8'b00_100_100, 8'd1, 8'd1, mk(1, 4, acc, 0, 0, 0)));
            if (FWD_ON) acc = acc + acc;
        end
        foreach (s[i]) begin
            sb.push_back(s[i].exp);
            drive(s[i]);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("[TB] FAIL back_to_back[%0d]: got %s, expected %s", i, show(got), show(exp));
            end
        end
    endtask

    task automatic test_jump_squash();
        step_t      s[$];
        logic [5:0] tq[$];
        logic [5:0] texp;
        obs_t       got, exp;
        tq.push_back(6'd42);
        tq.push_back(6'd21);
        s.push_back(mks(0, 8'h00,        8'd0,   8'd0,   mk(0, 4, B2B_LAST, 0, 0, 0)));
        s.push_back(mks(1, 8'b00_001_010, 8'd200, 8'd100, mk(1, 1, 8'd44, 0, 1, 0)));
        s.push_back(mks(1, 8'b11_101010,  8'd0,   8'd0,   mk(0, 1, 8'd44, 0, 1, 1)));
        s.push_back(mks(1, 8'b00_011_011, 8'd128, 8'd128, mk(0, 1, 8'd44, 0, 1, 0)));
        s.push_back(mks(1, 8'b11_010101,  8'd0,   8'd0,   mk(0, 1, 8'd44, 0, 1, 1)));
        s.push_back(mks(1, 8'b11_000111,  8'd0,   8'd0,   mk(0, 1, 8'd44, 0, 1, 0)));
        s.push_back(mks(0, 8'h00,        8'd0,   8'd0,   mk(0, 1, 8'd44, 0, 1, 0)));
        foreach (s[i]) begin
            sb.push_back(s[i].exp);
            drive(s[i]);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("[TB] FAIL jump_squash[%0d]: got %s, expected %s", i, show(got), show(exp));
            end
            if (exp.br && tq.size() > 0) begin
                texp = tq.pop_front();
                n_checks++;
                if (bus.br_target !== texp) begin
                    n_fail++;
                    $display("[TB] FAIL br_target[%0d]: got %0d, expected %0d", i, bus.br_target, texp);
                end
            end
        end
    endtask

    task automatic test_idle_mov();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mks(0, 8'h00,        8'd0, 8'd0, mk(0, 1, 8'd44, 0, 1, 0)));
        s.push_back(mks(1, 8'b10_110_011, 8'd0, 8'd7, mk(1, 6, 8'd7,  0, 1, 0)));
        s.push_back(mks(0, 8'h00,        8'd0, 8'd0, mk(0, 6, 8'd7,  0, 1, 0)));
        s.push_back(mks(1, 8'b10_101_000, 8'd9, 8'd0, mk(1, 5, 8'd0,  0, 1, 0)));
        foreach (s[i]) begin
            sb.push_back(s[i].exp);
            drive(s[i]);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("[TB] FAIL idle_mov[%0d]: got %s, expected %s", i, show(got), show(exp));
            end
        end
    endtask

    // Guard against a stalled run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] exwb_stage bench start (forwarding %0s)", FWD_ON ? "on" : "off");
        test_reset();
        test_add_carry();
        test_sub();
        test_forwarding();
        test_back_to_back();
        test_jump_squash();
        test_idle_mov();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
